temporizador_bcd: RTL

- Parametrised multi-digit BCD down-counter for the microwave cook timer.
- Successor to the single mod-10 digit counter: chains DIGITS decade stages with a selectable mod-6 seconds-tens stage (mm:ss).
- Adds a count-enable gated by an external 1 Hz tick strobe, a zero flag and a one-cycle done pulse.
- Sits between the keypad/load logic and the cook-control FSM; the display reads count.

---
 rtl/temporizador_pkg.sv | 24 ++
 rtl/contador_modn_digit.sv | 65 ++++++
 rtl/temporizador_bcd.sv | 88 ++++++++
 3 files changed

// File: rtl/temporizador_pkg.sv
// ============================================================================
// Module   : temporizador_pkg
// Purpose  : Shared constants and digit helpers for the BCD cook timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package temporizador_pkg;

    localparam int BCD_W = 4;

    // Digit 1 is the seconds-tens position when the mm:ss layout is selected.
    function automatic int digit_mod(input int i, input int mmss);
        return ((mmss != 0) && (i == 1)) ? 6 : 10;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] value,
                                                   input int modulus);
        return (int'(value) > (modulus - 1)) ? BCD_W'(modulus - 1) : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_modn_digit.sv
// ============================================================================
// Module   : contador_modn_digit
// Purpose  : One mod-N BCD digit with clamped load and a terminal-count flag.
//            Up-counting is compiled in with TEMPORIZADOR_BCD_UPDOWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_modn_digit
    import temporizador_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] data,
`ifdef TEMPORIZADOR_BCD_UPDOWN_EN
    input  logic             up,
`endif
    input  logic             step,
    output logic [BCD_W-1:0] count,
    output logic             tc
);

    localparam logic [BCD_W-1:0] c_max_val = BCD_W'(MOD - 1);

    logic [BCD_W-1:0] count_q;
    logic [BCD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = bcd_clamp(data, MOD);
        end else if (step) begin
`ifdef TEMPORIZADOR_BCD_UPDOWN_EN
            if (up) begin
                count_d = (count_q == c_max_val) ? '0 : count_q + 1'b1;
            end else begin
                count_d = (count_q == '0) ? c_max_val : count_q - 1'b1;
            end
`else
            count_d = (count_q == '0) ? c_max_val : count_q - 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`ifdef TEMPORIZADOR_BCD_UPDOWN_EN
    assign tc = up ? (count_q == c_max_val) : (count_q == '0);
`else
    assign tc = (count_q == '0);
`endif

endmodule

`default_nettype wire

// File: rtl/temporizador_bcd.sv
// ============================================================================
// Module   : temporizador_bcd
// Purpose  : Multi-digit BCD cook-timer down-counter (optional mm:ss layout),
//            tick-gated, with zero flag and done pulse.
//            Optional up-count mode: TEMPORIZADOR_BCD_UPDOWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador_bcd
    import temporizador_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int MMSS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] data,
`ifdef TEMPORIZADOR_BCD_UPDOWN_EN
    input  logic                    up,
`endif
    input  logic                    enable,
    input  logic                    tick,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    zero,
    output logic                    done
);

    logic [DIGITS-1:0] w_tc;
    logic [DIGITS-1:0] w_step;
    logic              w_blocked;
    logic              w_dec_en;
    logic              w_at_one;
    logic              done_q;
    logic              done_d;

    assign w_at_one = (count == (BCD_W*DIGITS)'(1));

    always_comb begin
`ifdef TEMPORIZADOR_BCD_UPDOWN_EN
        zero      = (count == '0);
        // Up mode saturates at all-max; down mode stops at zero.
        w_blocked = up ? (&w_tc) : zero;
        w_dec_en  = enable & tick & ~load & ~w_blocked;
        done_d    = w_dec_en & ~up & w_at_one;
`else
        zero      = &w_tc;
        w_blocked = zero;
        w_dec_en  = enable & tick & ~load & ~w_blocked;
        done_d    = w_dec_en & w_at_one;
`endif
        w_step[0] = w_dec_en;
        for (int i = 1; i < DIGITS; i++) begin
            w_step[i] = w_step[i-1] & w_tc[i-1];
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        contador_modn_digit #(
            .MOD (digit_mod(gi, MMSS))
        ) u_digit (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .data  (data[gi*BCD_W +: BCD_W]),
`ifdef TEMPORIZADOR_BCD_UPDOWN_EN
            .up    (up),
`endif
            .step  (w_step[gi]),
            .count (count[gi*BCD_W +: BCD_W]),
            .tc    (w_tc[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

`default_nettype wire
